ex_md_stage: RTL

- Parametrised execute stage with an iterative RV32M/RV64M multiply/divide unit.
- Single-cycle ALU results, taken from the combinational exu, pass straight into the EX/MEM pipeline register.
- MUL/DIV ops run an XLEN-step shift-add or restoring-divide engine, holding busy_o high so the hazard unit stalls IF/ID.
- Adds flush and a per-stage valid bit on top of the EX/MEM register.

---
 rtl/ex_md_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ex_md_stage.sv
// Execute stage with an EX/MEM pipeline register and an iterative RV32M/RV64M
// multiply/divide unit (one shift-add or restoring-divide step per cycle).
module ex_md_stage #(
  parameter int XLEN  = 32,
  parameter int SB_W  = 18,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic            md_en_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] port_a,
  input  logic [XLEN-1:0] port_b,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [SB_W-1:0] sb_i,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic [SB_W-1:0] sb_o,
  output logic            valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(XLEN - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [2:0]          r_op;
  logic                r_neg;
  logic                r_special;
  logic [XLEN-1:0]     r_specVal;
  logic [SB_W-1:0]     r_sb;

  logic                w_accept;
  logic                w_signedA;
  logic                w_signedB;
  logic                w_negA;
  logic                w_negB;
  logic [XLEN-1:0]     w_magA;
  logic [XLEN-1:0]     w_magB;
  logic                w_neg;
  logic                w_divZero;
  logic                w_ovf;
  logic [XLEN-1:0]     w_specVal;
  logic [XLEN:0]       w_mulSum;
  logic [XLEN:0]       w_remSh;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_prodFix;
  logic [XLEN-1:0]     w_divSel;
  logic [XLEN-1:0]     w_divFix;
  logic [XLEN-1:0]     w_mdResult;

  // Operand preparation at accept: signedness per funct3, magnitudes, result
  // sign, and the divide-by-zero / signed-overflow shortcut values.
  always_comb begin
    w_accept  = valid_i & md_en_i & ~flush_i;
    w_signedA = (md_op_i == 3'd1) | (md_op_i == 3'd2) | (md_op_i == 3'd4) | (md_op_i == 3'd6);
    w_signedB = (md_op_i == 3'd1) | (md_op_i == 3'd4) | (md_op_i == 3'd6);
    w_negA    = w_signedA & port_a[XLEN-1];
    w_negB    = w_signedB & port_b[XLEN-1];
    w_magA    = w_negA ? -port_a : port_a;
    w_magB    = w_negB ? -port_b : port_b;
    // remainder follows the dividend sign, everything else the sign product
    w_neg     = (md_op_i[2] & md_op_i[1]) ? w_negA : (w_negA ^ w_negB);
    w_divZero = md_op_i[2] & (port_b == '0);
    w_ovf     = md_op_i[2] & ~md_op_i[0] & (port_a == MinInt) & (port_b == '1);
    w_specVal = '0;
    if (w_divZero) begin
      w_specVal = md_op_i[1] ? port_a : '1;
    end else if (w_ovf) begin
      w_specVal = md_op_i[1] ? '0 : port_a;
    end
  end

  // One iteration of each engine; r_acc holds {hi,lo} product or {rem,quo}.
  always_comb begin
    w_mulSum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_remSh  = r_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_remSh - {1'b0, r_opnd};
  end

  // Sign fix-up and result selection used by the DONE write.
  always_comb begin
    w_prodFix = r_neg ? -r_acc : r_acc;
    w_divSel  = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    w_divFix  = r_neg ? -w_divSel : w_divSel;
    if (r_special) begin
      w_mdResult = r_specVal;
    end else if (r_op[2]) begin
      w_mdResult = w_divFix;
    end else if (r_op[1:0] == 2'd0) begin
      w_mdResult = w_prodFix[XLEN-1:0];
    end else begin
      w_mdResult = w_prodFix[2*XLEN-1:XLEN];
    end
  end

  // Upstream stall: the accept cycle, every iteration, and a DONE held by MEM.
  always_comb begin
    case (r_state)
      S_IDLE:  busy_o = w_accept;
      S_DONE:  busy_o = stall_i & ~flush_i;
      default: busy_o = 1'b1;
    endcase
  end

  // M-unit FSM together with the EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_specVal <= '0;
      r_sb      <= '0;
      result_o  <= '0;
      sb_o      <= '0;
      valid_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            if (!stall_i) valid_o <= 1'b0;
          end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= md_op_i;
            r_neg     <= w_neg;
            r_sb      <= sb_i;
            r_specVal <= w_specVal;
            r_special <= w_divZero | w_ovf;
            if (md_op_i[2]) begin
              r_opnd <= w_magB;
              r_acc  <= {{XLEN{1'b0}}, w_magA};
            end else begin
              r_opnd <= w_magA;
              r_acc  <= {{XLEN{1'b0}}, w_magB};
            end
            if (w_divZero | w_ovf) begin
              r_state <= S_DONE;
            end else if (md_op_i[2]) begin
              r_state <= S_DIV;
            end else begin
              r_state <= S_MUL;
            end
            if (!stall_i) valid_o <= 1'b0;
          end else if (!stall_i) begin
            result_o <= alu_result_i;
            sb_o     <= sb_i;
            valid_o  <= valid_i;
          end
        end
        S_MUL, S_DIV: begin
          if (!stall_i) valid_o <= 1'b0;
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            if (r_state == S_MUL) begin
              r_acc <= {w_mulSum, r_acc[XLEN-1:1]};
            end else if (!w_diff[XLEN]) begin
              r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
              r_acc <= {w_remSh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LastStep) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush_i) begin
            r_state <= S_IDLE;
            if (!stall_i) valid_o <= 1'b0;
          end else if (!stall_i) begin
            result_o <= w_mdResult;
            sb_o     <= r_sb;
            valid_o  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
